// File: rtl/distance_sched_pkg.sv
// distance_sched_pkg
//   Shared types for the distance delta sequencer and its datapath:
//   opt kind encoding, command select/op encodings, the command word,
//   and the sequencer FSM state.
package distance_sched_pkg;

    // opt_t.com encoding; the value 3 is illegal and handled as THR.
    localparam logic [1:0] THR = 2'd0;
    localparam logic [1:0] TWO = 2'd1;
    localparam logic [1:0] OR  = 2'd2;

    typedef enum logic [2:0] {
        KN = 3'd0,
        KP = 3'd1,
        KM = 3'd2,
        LN = 3'd3,
        LP = 3'd4,
        LM = 3'd5
    } distance_select_t;

    typedef enum logic [1:0] {
        DNOP = 2'd0,
        ZERO = 2'd1,
        PLS  = 2'd2,
        MNS  = 2'd3
    } distance_op_t;

    typedef struct packed {
        distance_select_t select;
        distance_op_t     op;
    } distance_command_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/distance_sched.sv
// distance_sched
//   Command sequencer for the distance delta datapath. Each accepted
//   request pulses opt_run, streams the fixed per-kind command words
//   (one per cycle), waits out the datapath latency and pulses done.
//
// Handshake: a request is accepted in a cycle where the block is idle
//   (busy=0 seen before acceptance) and start=1; busy then stays high
//   from that acceptance cycle through the done cycle inclusive. start
//   in any other cycle is ignored and never queued.
//
// Ports:
//   clk        clock
//   reset      synchronous active-high reset
//   start      request a delta evaluation
//   opt_kind   THR / TWO / OR, sampled on acceptance
//   busy       high from acceptance through done
//   opt_run    one-cycle pulse in the acceptance cycle
//   command    registered select/op word for the datapath
//   done       one-cycle pulse when delta_distance is final
//   fsm_state  current sequencer state, for observation
module distance_sched
    import distance_sched_pkg::*;
#(
    parameter int DP_LAT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        opt_kind,
    output logic              busy,
    output logic              opt_run,
    output distance_command_t command,
    output logic              done,
    output sched_state_t      fsm_state
);

    // Drain counter runs 1..DP_LAT-1; the done cycle itself is the
    // DP_LAT-th cycle after the last slot. Sized to hold DP_LAT.
    localparam int              DW         = (DP_LAT < 2) ? 1 : $clog2(DP_LAT + 1);
    localparam logic [DW-1:0]   DRAIN_LAST = DW'(DP_LAT - 1);
    localparam logic [DW-1:0]   DRAIN_ONE  = DW'(1);
    localparam bit              SKIP_DRAIN = (DP_LAT == 1);
    localparam distance_command_t IDLE_CMD = '{select: KN, op: DNOP};

    sched_state_t   state, state_n;
    logic [2:0]     slot, slot_n;
    logic [DW-1:0]  drain_cnt, drain_cnt_n;
    logic           is_or, is_or_n;
    logic           accept;
    logic [2:0]     last_slot;

    // Fixed command streams. Slot i's op applies to the distance between
    // the cities selected in slots i-1 and i; slot 0 clears the sum.
    function automatic distance_command_t slot_cmd(input logic use_or, input logic [2:0] idx);
        distance_command_t c;
        c = IDLE_CMD;
        if (use_or) begin
            case (idx)
                3'd0: c = '{select: KM, op: ZERO};
                3'd1: c = '{select: KN, op: MNS};
                3'd2: c = '{select: KP, op: MNS};
                3'd3: c = '{select: KM, op: PLS};
                3'd4: c = '{select: LN, op: DNOP};  // reposition only
                3'd5: c = '{select: LP, op: MNS};
                3'd6: c = '{select: KN, op: PLS};
                3'd7: c = '{select: LN, op: PLS};
                default: c = IDLE_CMD;
            endcase
        end else begin
            case (idx)
                3'd0: c = '{select: KN, op: ZERO};
                3'd1: c = '{select: KP, op: MNS};
                3'd2: c = '{select: LP, op: PLS};
                3'd3: c = '{select: LN, op: MNS};
                3'd4: c = '{select: KN, op: PLS};
                default: c = IDLE_CMD;
            endcase
        end
        return c;
    endfunction

    // Reset gates acceptance so no opt_run escapes in a reset cycle.
    assign accept    = (state == IDLE) && start && !reset;
    assign last_slot = is_or ? 3'd7 : 3'd4;

    always_comb begin
        state_n     = state;
        slot_n      = slot;
        drain_cnt_n = drain_cnt;
        is_or_n     = is_or;
        case (state)
            IDLE: begin
                if (accept) begin
                    is_or_n     = (opt_kind == OR);
                    slot_n      = 3'd0;
                    drain_cnt_n = DRAIN_ONE;
                    if (opt_kind == TWO || opt_kind == OR) begin
                        state_n = ISSUE;
                    end else begin
                        // THR and illegal kinds issue no slots.
                        state_n = SKIP_DRAIN ? DONE : DRAIN;
                    end
                end
            end
            ISSUE: begin
                if (slot == last_slot) begin
                    state_n     = SKIP_DRAIN ? DONE : DRAIN;
                    drain_cnt_n = DRAIN_ONE;
                end else begin
                    slot_n = slot + 3'd1;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_n = DONE;
                end else begin
                    drain_cnt_n = drain_cnt + DRAIN_ONE;
                end
            end
            DONE: begin
                state_n     = IDLE;
                slot_n      = 3'd0;
                drain_cnt_n = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            slot      <= 3'd0;
            drain_cnt <= '0;
            is_or     <= 1'b0;
            command   <= IDLE_CMD;
        end else begin
            state     <= state_n;
            slot      <= slot_n;
            drain_cnt <= drain_cnt_n;
            is_or     <= is_or_n;
            // Command is registered from the next state so slot i appears
            // exactly in the cycle the FSM sits on slot i.
            command   <= (state_n == ISSUE) ? slot_cmd(is_or_n, slot_n) : IDLE_CMD;
        end
    end

    assign busy      = (state != IDLE) || accept;
    assign opt_run   = accept;
    assign done      = (state == DONE);
    assign fsm_state = state;

endmodule
